// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller; byte/half stores are read-modify-write against a 4-byte RAM.
// Latency: err 1, load 2, word store 2, byte/half store 3 cycles; req_ready only in IDLE, no response backpressure.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout,
  output logic                  mem_write_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [1:0]            r_size_q;
  logic                  r_uns_q;
  logic                  r_we_q;
  logic                  r_err_q;
  logic [31:0]           r_buf_q;
  logic [31:0]           r_wdata_q;

  logic                  w_misalign;
  logic [31:0]           w_ext;
  logic [31:0]           w_merge;

  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      2'b01:   w_misalign = req_addr[0];
      2'b10:   w_misalign = |req_addr[1:0];
      2'b11:   w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
  end

  // Only bytes within the access size feed the load result.
  always_comb begin
    w_ext = mem_dout;
    case (r_size_q)
      2'b00:   w_ext = {{24{~r_uns_q & mem_dout[7]}}, mem_dout[7:0]};
      2'b01:   w_ext = {{16{~r_uns_q & mem_dout[15]}}, mem_dout[15:0]};
      default: w_ext = mem_dout;
    endcase
    w_merge = (r_size_q == 2'b00) ? {mem_dout[31:8], r_wdata_q[7:0]}
                                  : {mem_dout[31:16], r_wdata_q[15:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr_q  <= '0;
      r_size_q  <= '0;
      r_uns_q   <= 1'b0;
      r_we_q    <= 1'b0;
      r_err_q   <= 1'b0;
      r_buf_q   <= '0;
      r_wdata_q <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr_q  <= req_addr;
            r_size_q  <= req_size;
            r_uns_q   <= req_unsigned;
            r_we_q    <= req_we;
            r_wdata_q <= req_wdata;
            r_err_q   <= w_misalign;
            r_buf_q   <= '0;
            if (w_misalign) begin
              r_state <= S_RESP;
            end else if (!req_we) begin
              r_state <= S_LOAD;
            end else if (req_size == 2'b10) begin
              r_buf_q <= req_wdata;
              r_state <= S_WRITE;
            end else begin
              r_state <= S_MERGE;
            end
          end
        end
        S_LOAD: begin
          r_buf_q <= w_ext;
          r_state <= S_RESP;
        end
        S_MERGE: begin
          r_buf_q <= w_merge;
          r_state <= S_WRITE;
        end
        S_WRITE: r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state alone so a reset drops the write strobe immediately.
  assign req_ready      = (r_state == S_IDLE);
  assign resp_valid     = (r_state == S_RESP);
  assign resp_err       = (r_state == S_RESP) && r_err_q;
  assign resp_rdata     = ((r_state == S_RESP) && !r_we_q && !r_err_q) ? r_buf_q : 32'd0;
  assign mem_read_addr  = ((r_state == S_LOAD) || (r_state == S_MERGE)) ? r_addr_q : '0;
  assign mem_write_addr = (r_state == S_WRITE) ? r_addr_q : '0;
  assign mem_din        = (r_state == S_WRITE) ? r_buf_q : 32'd0;
  assign mem_write_en   = (r_state == S_WRITE);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-addressed RAM model (4-byte window, 12-bit wrap).
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [11:0] mem_read_addr;
  logic [11:0] mem_write_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_write_en;

  int n_cmp;
  int n_fail;

  logic [7:0] ram [0:4095];

  lsu_mem_ctrl #(.ADDR_WIDTH(12)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read_addr  (mem_read_addr),
    .mem_write_addr (mem_write_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_write_en   (mem_write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_dout = {ram[12'(mem_read_addr + 12'd3)], ram[12'(mem_read_addr + 12'd2)],
                ram[12'(mem_read_addr + 12'd1)], ram[mem_read_addr]};
  end

  always @(posedge clk) begin
    if (mem_write_en) begin
      for (int k = 0; k < 4; k++) ram[12'(mem_write_addr + 12'(k))] = mem_din[8*k +: 8];
    end
  end

  task automatic poke(input logic [11:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) ram[12'(a + 12'(k))] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] peek(input logic [11:0] a);
    return {ram[12'(a + 12'd3)], ram[12'(a + 12'd2)], ram[12'(a + 12'd1)], ram[a]};
  endfunction

  // Issues one request from IDLE; reports cycles from accepting edge to resp_valid.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int wen);
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wen = 0; rdata = 32'hx; err = 1'bx;
    while (1) begin
      if (mem_write_en) wen++;
      if (resp_valid) begin
        rdata = resp_rdata; err = resp_err;
        break;
      end
      if (lat >= 10) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout: no resp_valid within %0d cycles (addr %h)", lat, addr);
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin n_fail++;
      $display("FAIL reset_resp: got rdata %h err %b want 0/0", resp_rdata, resp_err); end
    n_cmp++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", mem_write_en); end
    n_cmp++; if (mem_read_addr !== 12'd0 || mem_write_addr !== 12'd0 || mem_din !== 32'd0) begin n_fail++;
      $display("FAIL reset_mem_bus: got ra %h wa %h din %h want 0", mem_read_addr, mem_write_addr, mem_din); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    int lat, wen; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, lat, rd, er, wen);
    n_cmp++; if (lat !== 2 || wen !== 1) begin n_fail++;
      $display("FAIL sw_timing: got lat %0d wen %0d want 2/1", lat, wen); end
    n_cmp++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++;
      $display("FAIL sw_resp: got rdata %h err %b want 0/0", rd, er); end
    n_cmp++; if (peek(12'h010) !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL sw_ram: got %h want deadbeef", peek(12'h010)); end
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'd0, lat, rd, er, wen);
    n_cmp++; if (lat !== 2 || wen !== 0) begin n_fail++;
      $display("FAIL lw_timing: got lat %0d wen %0d want 2/0", lat, wen); end
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++;
      $display("FAIL lw_resp: got rdata %h err %b want deadbeef/0", rd, er); end
  endtask

  task automatic test_byte_rmw();
    int lat, wen; logic [31:0] rd; logic er;
    poke(12'h020, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 12'h021, 32'h123456AA, lat, rd, er, wen);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", lat); end
    n_cmp++; if (wen !== 1) begin n_fail++; $display("FAIL sb_wen_cycles: got %0d want 1", wen); end
    n_cmp++; if (peek(12'h020) !== 32'h1122AA44) begin n_fail++;
      $display("FAIL sb_ram: got %h want 1122aa44", peek(12'h020)); end
    // Halfword RMW at the top of the address space wraps into bytes 0..1.
    poke(12'hFFC, 32'hA1B2C3D4); poke(12'h000, 32'h0000E5F6);
    do_req(1'b1, 2'b01, 1'b0, 12'hFFE, 32'hFFFF1357, lat, rd, er, wen);
    n_cmp++; if (peek(12'hFFC) !== 32'h1357C3D4 || peek(12'h000) !== 32'h0000E5F6) begin n_fail++;
      $display("FAIL sh_wrap: got %h/%h want 1357c3d4/0000e5f6", peek(12'hFFC), peek(12'h000)); end
  endtask

  task automatic test_extend();
    int lat, wen; logic [31:0] rd; logic er;
    poke(12'h030, 32'h000080F0);
    do_req(1'b0, 2'b00, 1'b0, 12'h030, 32'd0, lat, rd, er, wen);
    n_cmp++; if (rd !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb: got %h want fffffff0", rd); end
    do_req(1'b0, 2'b00, 1'b1, 12'h030, 32'd0, lat, rd, er, wen);
    n_cmp++; if (rd !== 32'h000000F0) begin n_fail++; $display("FAIL lbu: got %h want 000000f0", rd); end
    do_req(1'b0, 2'b01, 1'b0, 12'h030, 32'd0, lat, rd, er, wen);
    n_cmp++; if (rd !== 32'hFFFF80F0) begin n_fail++; $display("FAIL lh: got %h want ffff80f0", rd); end
    do_req(1'b0, 2'b01, 1'b1, 12'h030, 32'd0, lat, rd, er, wen);
    n_cmp++; if (rd !== 32'h000080F0) begin n_fail++; $display("FAIL lhu: got %h want 000080f0", rd); end
    n_cmp++; if (lat !== 2 || er !== 1'b0) begin n_fail++;
      $display("FAIL lhu_timing: got lat %0d err %b want 2/0", lat, er); end
  endtask

  task automatic test_misaligned();
    int lat, wen; logic [31:0] rd; logic er;
    logic [11:0] a [3]; logic [1:0] sz [3]; logic w [3];
    a[0] = 12'h031; sz[0] = 2'b01; w[0] = 1'b0;
    a[1] = 12'h032; sz[1] = 2'b10; w[1] = 1'b1;
    a[2] = 12'h030; sz[2] = 2'b11; w[2] = 1'b1;
    poke(12'h030, 32'h000080F0); poke(12'h034, 32'h0BADF00D);
    for (int i = 0; i < 3; i++) begin
      do_req(w[i], sz[i], 1'b0, a[i], 32'hCAFEBABE, lat, rd, er, wen);
      n_cmp++; if (er !== 1'b1 || lat !== 1) begin n_fail++;
        $display("FAIL err_%0d: got err %b lat %0d want 1/1", i, er, lat); end
      n_cmp++; if (rd !== 32'd0 || wen !== 0) begin n_fail++;
        $display("FAIL err_side_%0d: got rdata %h wen %0d want 0/0", i, rd, wen); end
    end
    n_cmp++; if (peek(12'h030) !== 32'h000080F0 || peek(12'h034) !== 32'h0BADF00D) begin n_fail++;
      $display("FAIL err_ram: got %h/%h want 000080f0/0badf00d", peek(12'h030), peek(12'h034)); end
  endtask

  task automatic test_reset_mid_merge();
    int bad_wen, bad_resp;
    poke(12'h040, 32'h55667788);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 12'h040;
    req_wdata = 32'h000000EE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    bad_wen = 0; bad_resp = 0;
    if (mem_write_en) bad_wen++;
    if (resp_valid) bad_resp++;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (mem_write_en) bad_wen++;
      if (resp_valid) bad_resp++;
    end
    n_cmp++; if (bad_wen !== 0 || bad_resp !== 0) begin n_fail++;
      $display("FAIL rst_mid_quiet: got wen %0d resp %0d want 0/0", bad_wen, bad_resp); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready_after: got %b want 1", req_ready); end
    n_cmp++; if (peek(12'h040) !== 32'h55667788) begin n_fail++;
      $display("FAIL rst_mid_ram: got %h want 55667788", peek(12'h040)); end
  endtask

  task automatic set_hs_req(input int idx);
    case (idx)
      0: begin req_we = 1'b1; req_size = 2'b10; req_addr = 12'h050; req_wdata = 32'h12345678; end
      1: begin req_we = 1'b0; req_size = 2'b10; req_addr = 12'h050; req_wdata = 32'd0; end
      2: begin req_we = 1'b1; req_size = 2'b01; req_addr = 12'h052; req_wdata = 32'h0000BEEF; end
      default: begin req_we = 1'b0; req_size = 2'b10; req_addr = 12'h050; req_wdata = 32'd0; end
    endcase
    req_unsigned = 1'b0;
  endtask

  task automatic test_back_to_back();
    int idx, nresp; logic pend;
    logic [31:0] rd [4]; logic er [4];
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'd0; exp_rd[1] = 32'h12345678; exp_rd[2] = 32'd0; exp_rd[3] = 32'hBEEF5678;
    for (int i = 0; i < 4; i++) begin rd[i] = 32'hx; er[i] = 1'bx; end
    poke(12'h050, 32'h0); poke(12'h054, 32'h0);
    @(negedge clk);
    idx = 0; nresp = 0;
    set_hs_req(0);
    req_valid = 1'b1;
    pend = req_ready;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (pend) begin
        idx++;
        pend = 1'b0;
        if (idx < 4) set_hs_req(idx);
        else req_valid = 1'b0;
      end
      if (resp_valid) begin
        if (nresp < 4) begin rd[nresp] = resp_rdata; er[nresp] = resp_err; end
        nresp++;
      end
      if (req_valid && req_ready) pend = 1'b1;
    end
    n_cmp++; if (idx !== 4 || nresp !== 4) begin n_fail++;
      $display("FAIL b2b_counts: got accepted %0d responses %0d want 4/4", idx, nresp); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rd[i] !== exp_rd[i] || er[i] !== 1'b0) begin n_fail++;
        $display("FAIL b2b_resp_%0d: got rdata %h err %b want %h/0", i, rd[i], er[i], exp_rd[i]); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 12'd0; req_wdata = 32'd0;
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_extend();
    test_misaligned();
    test_reset_mid_merge();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
